// File: rtl/awg_pkg.sv
// Shared AWG constants: datapath widths, reset defaults, command characters
// and the parser state encoding.
package awg_pkg;

  localparam int AWG_FREQ_W  = 12;
  localparam int AWG_AMP_W   = 3;
  localparam int AWG_PHASE_W = 8;
  localparam int AWG_WAVE_W  = 5;

  localparam int AWG_DEF_FREQ  = 1000;
  localparam int AWG_DEF_AMP   = 4;
  localparam int AWG_DEF_PHASE = 50;
  localparam int AWG_DEF_WAVE  = 3;

  // 99999 is the largest five-digit value; it needs 17 bits.
  localparam int ACC_W      = 17;
  localparam int CNT_W      = 3;
  localparam int MAX_DIGITS = 5;

  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_COMMIT} state_e;
  typedef enum logic [1:0] {TGT_FREQ, TGT_AMP, TGT_PHASE, TGT_WAVE} target_e;

  function automatic logic is_cmd(input logic [7:0] c);
    return (c == CH_F) || (c == CH_A) || (c == CH_P) || (c == CH_W);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

  function automatic logic is_blank(input logic [7:0] c);
    return is_term(c) || (c == CH_SP);
  endfunction

  function automatic target_e cmd_target(input logic [7:0] c);
    case (c)
      CH_A:    return TGT_AMP;
      CH_P:    return TGT_PHASE;
      CH_W:    return TGT_WAVE;
      default: return TGT_FREQ;
    endcase
  endfunction

endpackage

// File: rtl/awg_dec_acc.sv
// Decimal accumulator: acc = acc*10 + digit via shift-add, with a digit
// counter and a flag once five digits are held.
module awg_dec_acc
  import awg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  assign full = (count == CNT_W'(MAX_DIGITS));

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (clr) begin
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= (acc << 3) + (acc << 1) + ACC_W'(digit);
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/awg_cmd_parser.sv
// ASCII command parser (F/A/P/W + 1..5 digits + CR/LF) that range-checks
// values and commits them to the DDS configuration registers.
module awg_cmd_parser
  import awg_pkg::*;
#(
  parameter int FREQ_W    = AWG_FREQ_W,
  parameter int AMP_W     = AWG_AMP_W,
  parameter int PHASE_W   = AWG_PHASE_W,
  parameter int WAVE_W    = AWG_WAVE_W,
  parameter int DEF_FREQ  = AWG_DEF_FREQ,
  parameter int DEF_AMP   = AWG_DEF_AMP,
  parameter int DEF_PHASE = AWG_DEF_PHASE,
  parameter int DEF_WAVE  = AWG_DEF_WAVE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [WAVE_W-1:0]  wave_sel,
  output logic [FREQ_W-1:0]  freq,
  output logic [AMP_W-1:0]   amp,
  output logic [PHASE_W-1:0] phase,
  output logic               cfg_update,
  output logic               cmd_err,
  output logic               busy
);

  state_e           state, state_nx;
  target_e          tgt, tgt_nx;
  logic             acc_clr, acc_load, err_now, err_pend;
  logic [ACC_W-1:0] acc, lim;
  logic [CNT_W-1:0] count;
  logic             full;

  awg_dec_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .load  (acc_load),
    .digit (rx_data[3:0]),
    .acc   (acc),
    .count (count),
    .full  (full)
  );

  always_comb begin
    lim = '0;
    unique case (tgt)
      TGT_FREQ:  lim = (ACC_W'(1) << FREQ_W)  - ACC_W'(1);
      TGT_AMP:   lim = (ACC_W'(1) << AMP_W)   - ACC_W'(1);
      TGT_PHASE: lim = (ACC_W'(1) << PHASE_W) - ACC_W'(1);
      TGT_WAVE:  lim = (ACC_W'(1) << WAVE_W)  - ACC_W'(1);
    endcase
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    err_now  = 1'b0;
    unique case (state)
      ST_IDLE: if (rx_valid) begin
        if (is_cmd(rx_data)) begin
          tgt_nx   = cmd_target(rx_data);
          acc_clr  = 1'b1;
          state_nx = ST_ACC;
        end else if (!is_blank(rx_data)) begin
          err_now = 1'b1;
        end
      end
      ST_ACC: if (rx_valid) begin
        if (is_digit(rx_data)) begin
          if (full) begin
            err_now  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            acc_load = 1'b1;
          end
        end else if (is_term(rx_data)) begin
          if (count == '0 || acc > lim) begin
            err_now  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_COMMIT;
          end
        end else if (is_cmd(rx_data)) begin
          // Resync on a fresh command letter rather than losing it.
          err_now = 1'b1;
          tgt_nx  = cmd_target(rx_data);
          acc_clr = 1'b1;
        end else begin
          err_now  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // A byte dropped in COMMIT reports its error one cycle late so it never
  // overlaps the cfg_update pulse of the commit it collided with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tgt        <= TGT_FREQ;
      err_pend   <= 1'b0;
      cmd_err    <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      state      <= state_nx;
      tgt        <= tgt_nx;
      err_pend   <= rx_valid && (state == ST_COMMIT);
      cmd_err    <= err_now || err_pend;
      cfg_update <= (state == ST_COMMIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq     <= FREQ_W'(DEF_FREQ);
      amp      <= AMP_W'(DEF_AMP);
      phase    <= PHASE_W'(DEF_PHASE);
      wave_sel <= WAVE_W'(DEF_WAVE);
    end else if (state == ST_COMMIT) begin
      unique case (tgt)
        TGT_FREQ:  freq     <= acc[FREQ_W-1:0];
        TGT_AMP:   amp      <= acc[AMP_W-1:0];
        TGT_PHASE: phase    <= acc[PHASE_W-1:0];
        TGT_WAVE:  wave_sel <= acc[WAVE_W-1:0];
      endcase
    end
  end

  assign busy = (state == ST_COMMIT);

endmodule

// File: tb/tb_awg_cmd_parser.sv
// Scoreboard bench for awg_cmd_parser: a byte-level grammar model predicts
// every cfg_update / cmd_err pulse (cycle and register values) and busy.
module tb_awg_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [4:0]  wave_sel;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;
  logic        cfg_update, cmd_err, busy;

  awg_cmd_parser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wave_sel   (wave_sel),
    .freq       (freq),
    .amp        (amp),
    .phase      (phase),
    .cfg_update (cfg_update),
    .cmd_err    (cmd_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit upd;
    int cyc;
    int f, a, p, w;
  } ev_t;

  ev_t exp_q[$];
  int  busy_q[$];
  int  n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_freq, m_amp, m_phase, m_wave;
  bit  m_collect;
  int  m_tgt, m_val, m_cnt;
  int  commit_at, last_err;

  function automatic void model_reset();
    m_freq = 1000; m_amp = 4; m_phase = 50; m_wave = 3;
    m_collect = 0; m_tgt = 0; m_val = 0; m_cnt = 0;
    commit_at = -10; last_err = -10;
  endfunction

  function automatic void push_ev(input bit upd, input int c);
    ev_t e;
    if (!upd) begin
      if (c == last_err) return;
      last_err = c;
    end
    e.upd = upd; e.cyc = c;
    e.f = m_freq; e.a = m_amp; e.p = m_phase; e.w = m_wave;
    exp_q.push_back(e);
  endfunction

  function automatic bit m_is_cmd(input int b);
    return b == "F" || b == "A" || b == "P" || b == "W";
  endfunction

  function automatic int m_max(input int t);
    case (t)
      "F":     return 2**12 - 1;
      "A":     return 2**3 - 1;
      "P":     return 2**8 - 1;
      default: return 2**5 - 1;
    endcase
  endfunction

  // Byte driven while cyc == m is sampled at the edge that makes cyc m+1;
  // its error is visible at cyc m+1, a commit is visible at cyc m+2.
  function automatic void model_byte(input int b, input int m);
    int s = m + 1;
    bit digit = (b >= "0") && (b <= "9");
    bit term  = (b == 8'h0D) || (b == 8'h0A);
    if (s == commit_at) begin
      push_ev(0, s + 1);
      return;
    end
    if (!m_collect) begin
      if (m_is_cmd(b)) begin
        m_collect = 1; m_tgt = b; m_val = 0; m_cnt = 0;
      end else if (!(term || b == 8'h20)) begin
        push_ev(0, s);
      end
    end else if (digit) begin
      if (m_cnt == 5) begin
        push_ev(0, s); m_collect = 0;
      end else begin
        m_val = m_val * 10 + (b - "0"); m_cnt++;
      end
    end else if (term) begin
      m_collect = 0;
      if (m_cnt == 0 || m_val > m_max(m_tgt)) push_ev(0, s);
      else begin
        case (m_tgt)
          "F":     m_freq  = m_val;
          "A":     m_amp   = m_val;
          "P":     m_phase = m_val;
          default: m_wave  = m_val;
        endcase
        busy_q.push_back(s);
        push_ev(1, s + 1);
        commit_at = s + 1;
      end
    end else if (m_is_cmd(b)) begin
      push_ev(0, s); m_tgt = b; m_val = 0; m_cnt = 0;
    end else begin
      push_ev(0, s); m_collect = 0;
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_b;
      ev_t e;
      if (cfg_update && cmd_err) check("pulse_overlap", 1, 0);
      while (busy_q.size() != 0 && busy_q[0] < cyc) begin
        void'(busy_q.pop_front());
        check("busy_missed", 0, 1);
      end
      exp_b = (busy_q.size() != 0) && (busy_q[0] == cyc);
      if (busy || exp_b) check("busy", int'(busy), int'(exp_b));
      if (exp_b) void'(busy_q.pop_front());
      if (cfg_update || cmd_err) begin
        if (exp_q.size() == 0) check("unexpected_pulse", int'(cfg_update) * 2 + int'(cmd_err), 0);
        else begin
          e = exp_q.pop_front();
          check("pulse_kind_upd", int'(cfg_update), int'(e.upd));
          check("pulse_cycle", cyc, e.cyc);
          check("freq", int'(freq), e.f);
          check("amp", int'(amp), e.a);
          check("phase", int'(phase), e.p);
          check("wave_sel", int'(wave_sel), e.w);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("pulse_missed_at", cyc, e.cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(int'(b), cyc);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int last_gap);
    for (int i = 0; i < s.len(); i++) send(s[i], (i == s.len() - 1) ? last_gap : 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy_q.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("drain_timeout", exp_q.size() + busy_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_freq"}, int'(freq), m_freq);
    check({tag, "_amp"}, int'(amp), m_amp);
    check({tag, "_phase"}, int'(phase), m_phase);
    check({tag, "_wave"}, int'(wave_sel), m_wave);
  endtask

  task automatic check_defaults(input string tag);
    check({tag, "_freq"}, int'(freq), 1000);
    check({tag, "_amp"}, int'(amp), 4);
    check({tag, "_phase"}, int'(phase), 50);
    check({tag, "_wave"}, int'(wave_sel), 3);
    check({tag, "_pulses"}, int'(cfg_update) + int'(cmd_err) + int'(busy), 0);
  endtask

  function automatic int rand_gap();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2));
  endfunction

  initial begin
    logic [7:0] cmds[4];
    logic [7:0] junk[6];
    cmds = '{8'h46, 8'h41, 8'h50, 8'h57};
    junk = '{8'h78, 8'h66, 8'h20, 8'h0D, 8'h3F, 8'h5A};
    model_reset();
    repeat (3) @(negedge clk);
    check_defaults("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send_str("\r\n ", 2);   drain(); check_regs("blank");
    send_str("F524\r", 2);  drain(); check("F524_freq", int'(freq), 524);
    send_str("A9\n", 2);    drain(); check("A9_amp", int'(amp), 4);
    send_str("P256\r", 2);  drain(); check("P256_phase", int'(phase), 50);
    send_str("P255\r", 2);  drain(); check("P255_phase", int'(phase), 255);
    send_str("F123456\r", 2); drain(); check("F6dig_freq", int'(freq), 524);
    send_str("F12xW2\r", 2);  drain(); check("resync_wave", int'(wave_sel), 2);
    send_str("F1A5\r", 2);  drain(); check("F1A5_amp", int'(amp), 5);
    check("F1A5_freq", int'(freq), 524);
    send_str("F\r", 2);     drain(); check_regs("Fempty");
    send_str("W7\r", 0);
    send(8'h35, 2);         drain(); check("W7_wave", int'(wave_sel), 7);

    send_str("F99", 1);     drain();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_defaults("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_str("\r", 2);      drain(); check_regs("post_reset");

    for (int k = 0; k < 300; k++) begin
      int nd = $urandom_range(0, 6);
      if ($urandom_range(0, 5) == 0) send(junk[$urandom_range(0, 5)], rand_gap());
      send(cmds[$urandom_range(0, 3)], rand_gap());
      for (int d = 0; d < nd; d++) begin
        if ($urandom_range(0, 24) == 0) send(junk[$urandom_range(0, 5)], rand_gap());
        send(8'(8'h30 + $urandom_range(0, 9)), rand_gap());
      end
      send(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A, rand_gap());
    end
    drain();
    check_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
